// File: rtl/puf_ctrl_pkg.sv
// Shared types and default sizing for the arbiter PUF evaluation sequencer.
package puf_ctrl_pkg;

    localparam int CHAL_W_DEF     = 32;
    localparam int NUM_EVAL_DEF   = 32;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int PULSE_CYC_DEF  = 2;
    localparam int SAMPLE_CYC_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PULSE_HI,
        PULSE_LO,
        DONE
    } puf_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for the raw PUF response.
module puf_resp_sync (
    input  logic iclk,
    input  logic irst_n,
    input  logic iasync,
    output logic osync
);

    logic meta;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            meta  <= 1'b0;
            osync <= 1'b0;
        end else begin
            meta  <= iasync;
            osync <= meta;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Holds one challenge on the PUF, fires NUM_EVAL pulses and
// collects the synchronized response after each one.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int NUM_EVAL   = NUM_EVAL_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int PULSE_CYC  = PULSE_CYC_DEF,
    parameter int SAMPLE_CYC = SAMPLE_CYC_DEF
) (
    input  logic                            iclk,
    input  logic                            irst_n,
    input  logic                            ichal_valid,
    output logic                            ichal_ready,
    input  logic [CHAL_W-1:0]               ichallenge,
    input  logic                            iabort,
    output logic [CHAL_W-1:0]               opuf_challenge,
    output logic                            opuf_pulse,
    input  logic                            ipuf_response,
    output logic                            oresult_valid,
    input  logic                            iresult_ready,
    output logic [NUM_EVAL-1:0]             oresp_vec,
    output logic [$clog2(NUM_EVAL+1)-1:0]   oones_cnt,
    output logic                            oresp_bit,
    output logic                            ostable
);

    localparam int CNT_W = $clog2(NUM_EVAL + 1);
    localparam int IDX_W = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;
    localparam int CYC_W =
        $clog2(max3(SETTLE_CYC, PULSE_CYC, SAMPLE_CYC) + 1);

    localparam logic [CYC_W-1:0] SETTLE_LD = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] PULSE_LD  = CYC_W'(PULSE_CYC - 1);
    localparam logic [CYC_W-1:0] SAMPLE_LD = CYC_W'(SAMPLE_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_EVAL - 1);

    puf_state_e       state;
    logic [CYC_W-1:0] cyc;
    logic [IDX_W-1:0] eval_idx;
    logic             resp_sync;
    logic             cyc_done;
    logic             abort_now;

    puf_resp_sync u_sync (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iasync (ipuf_response),
        .osync  (resp_sync)
    );

    assign cyc_done    = (cyc == '0);
    assign ichal_ready = (state == IDLE);
    assign abort_now   = iabort &&
                         (state inside {SETTLE, PULSE_HI, PULSE_LO});

    // Consumers qualify these with oresult_valid.
    assign oresp_bit = (oones_cnt > CNT_W'(NUM_EVAL / 2));
    assign ostable   = (oones_cnt == '0) ||
                       (oones_cnt == CNT_W'(NUM_EVAL));

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state          <= IDLE;
            cyc            <= '0;
            eval_idx       <= '0;
            opuf_challenge <= '0;
            opuf_pulse     <= 1'b0;
            oresult_valid  <= 1'b0;
            oresp_vec      <= '0;
            oones_cnt      <= '0;
        end else if (abort_now) begin
            // Partial results stay visible until the next accept.
            state      <= IDLE;
            opuf_pulse <= 1'b0;
            cyc        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ichal_valid) begin
                        opuf_challenge <= ichallenge;
                        eval_idx       <= '0;
                        oresp_vec      <= '0;
                        oones_cnt      <= '0;
                        cyc            <= SETTLE_LD;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cyc_done) begin
                        opuf_pulse <= 1'b1;
                        cyc        <= PULSE_LD;
                        state      <= PULSE_HI;
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                PULSE_HI: begin
                    if (cyc_done) begin
                        opuf_pulse <= 1'b0;
                        cyc        <= SAMPLE_LD;
                        state      <= PULSE_LO;
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                PULSE_LO: begin
                    if (cyc_done) begin
                        oresp_vec[eval_idx] <= resp_sync;
                        oones_cnt <= oones_cnt + CNT_W'(resp_sync);
                        if (eval_idx == LAST_IDX) begin
                            oresult_valid <= 1'b1;
                            cyc           <= '0;
                            state         <= DONE;
                        end else begin
                            eval_idx   <= eval_idx + IDX_W'(1);
                            opuf_pulse <= 1'b1;
                            cyc        <= PULSE_LD;
                            state      <= PULSE_HI;
                        end
                    end else begin
                        cyc <= cyc - CYC_W'(1);
                    end
                end
                DONE: begin
                    if (iresult_ready) begin
                        oresult_valid <= 1'b0;
                        cyc           <= '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
